// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampled UART receiver with valid/ready byte output
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   data_out   last accepted received byte
//   data_valid data_out holds an unconsumed byte
//   data_ready consumer accepts the byte when data_valid && data_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while data_valid still high
//   busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_q;
    logic            rx_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [SW-1:0]   s_cnt;
    logic [2:0]      b_cnt;
    logic [7:0]      shreg;
    logic            brk;       // stop bit was low; waiting for the line to return high
    logic            s_hit_mid;
    logic            s_hit_last;
    logic            enter_start;
    logic            byte_done;
    logic            stop_bad;
    logic            xfer;

    assign tick       = (tick_cnt == TICK_MAX);
    assign s_hit_mid  = tick && (s_cnt == S_MID);
    assign s_hit_last = tick && (s_cnt == S_LAST);
    assign xfer       = data_valid && data_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: if (s_hit_mid) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (s_hit_last && (b_cnt == 3'd7)) state_nxt = STOP;
            STOP: begin
                if (brk) begin
                    if (rx_s) state_nxt = IDLE;
                end else if (s_hit_last && rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded strobes
    always_comb begin
        busy        = (state != IDLE);
        enter_start = (state == IDLE) && !rx_s;
        byte_done   = (state == STOP) && !brk && s_hit_last && rx_s;
        stop_bad    = (state == STOP) && !brk && s_hit_last && !rx_s;
    end

    // Synchroniser, tick divider, counters and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q     <= 1'b1;
            rx_s     <= 1'b1;
            tick_cnt <= '0;
            s_cnt    <= '0;
            b_cnt    <= 3'd0;
            shreg    <= 8'h00;
            brk      <= 1'b0;
        end else begin
            rx_q <= rx;
            rx_s <= rx_q;

            // Realign the divider to the detected falling edge.
            if (enter_start || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if ((state == IDLE) || ((state == START) && s_hit_mid) || s_hit_last) begin
                s_cnt <= '0;
            end else if (tick) begin
                s_cnt <= s_cnt + 1'b1;
            end

            if (state != DATA) begin
                b_cnt <= 3'd0;
            end else if (s_hit_last) begin
                b_cnt <= b_cnt + 3'd1;
            end

            if ((state == DATA) && s_hit_last) begin
                shreg[b_cnt] <= rx_s;
            end

            if (state != STOP) begin
                brk <= 1'b0;
            end else if (stop_bad) begin
                brk <= 1'b1;
            end
        end
    end

    // Byte output handshake and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && data_valid && !data_ready;
            if (byte_done && (!data_valid || data_ready)) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
            end else if (xfer) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total;
    int bad;
    int fe_cnt;
    int ov_cnt;
    int rec_n;
    logic [7:0] rec [8];
    logic busy_mid;
    logic dv_at_stop;

    uart_rx #(
        .CLK_FREQ  (1600000),
        .BAUD_RATE (10000),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (data_valid && data_ready) begin
            if (rec_n < 8) rec[rec_n] = data_out;
            rec_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, stop bit of the given level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 9) dv_at_stop = data_valid;
            step(BIT_CLKS / 2);
            if (i == 4) busy_mid = busy;
            step(BIT_CLKS / 2);
        end
        rx = 1'b1;
    endtask

    task automatic pulse_ready();
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
    endtask

    task automatic clear_counts();
        fe_cnt = 0;
        ov_cnt = 0;
        rec_n  = 0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        clear_counts();
        busy_mid = 1'b0;
        dv_at_stop = 1'b0;
        rx = 1'b1;
        data_ready = 1'b0;
        rst_n = 1'b0;
        step(5);
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step(20);

        // 1: single frame, consumer idle
        clear_counts();
        send_frame(8'hA5, 1'b1);
        chk("t1_busy_mid", 32'(busy_mid), 1);
        chk("t1_valid_early", 32'(dv_at_stop), 0);
        chk("t1_valid", 32'(data_valid), 1);
        chk("t1_data", 32'(data_out), 32'hA5);
        chk("t1_fe", 32'(fe_cnt), 0);
        chk("t1_ov", 32'(ov_cnt), 0);
        step(30);
        chk("t1_data_hold", 32'(data_out), 32'hA5);
        pulse_ready();
        chk("t1_valid_clr", 32'(data_valid), 0);
        step(50);

        // 2: short low glitch while idle
        clear_counts();
        rx = 1'b0;
        step(30);
        chk("t2_busy_in", 32'(busy), 1);
        step(30);
        rx = 1'b1;
        step(30);
        chk("t2_busy_drop", 32'(busy), 0);
        chk("t2_valid", 32'(data_valid), 0);
        step(200);
        chk("t2_busy_late", 32'(busy), 0);

        // 3: framing error then recovery
        clear_counts();
        send_frame(8'h3C, 1'b0);
        step(200);
        chk("t3_fe_cnt", 32'(fe_cnt), 1);
        chk("t3_valid", 32'(data_valid), 0);
        chk("t3_busy", 32'(busy), 0);
        send_frame(8'h42, 1'b1);
        step(10);
        chk("t3_valid2", 32'(data_valid), 1);
        chk("t3_data2", 32'(data_out), 32'h42);
        chk("t3_fe_after", 32'(fe_cnt), 1);
        pulse_ready();
        step(50);

        // 4: overrun
        clear_counts();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(10);
        chk("t4_data", 32'(data_out), 32'h11);
        chk("t4_valid", 32'(data_valid), 1);
        chk("t4_ov", 32'(ov_cnt), 1);
        chk("t4_fe", 32'(fe_cnt), 0);
        pulse_ready();
        chk("t4_valid_clr", 32'(data_valid), 0);
        step(50);

        // 5: back-to-back with consumer always ready
        clear_counts();
        data_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        step(10);
        chk("t5_count", 32'(rec_n), 2);
        chk("t5_byte0", 32'(rec[0]), 32'h55);
        chk("t5_byte1", 32'(rec[1]), 32'hAA);
        chk("t5_ov", 32'(ov_cnt), 0);
        chk("t5_fe", 32'(fe_cnt), 0);
        chk("t5_valid", 32'(data_valid), 0);
        data_ready = 1'b0;
        step(50);

        // 6: reset mid-frame, then recover
        clear_counts();
        send_frame(8'h33, 1'b1);
        chk("t6_valid_pre", 32'(data_valid), 1);
        rx = 1'b0;
        step(BIT_CLKS);
        rx = 1'b1;
        step(3 * BIT_CLKS);
        chk("t6_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_valid", 32'(data_valid), 0);
        chk("t6_async_data", 32'(data_out), 32'h00);
        step(5);
        rst_n = 1'b1;
        step(20);
        chk("t6_fe", 32'(fe_cnt), 0);
        chk("t6_ov", 32'(ov_cnt), 0);
        send_frame(8'h81, 1'b1);
        step(10);
        chk("t6_valid", 32'(data_valid), 1);
        chk("t6_data", 32'(data_out), 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 format, LSB first.
- Companion to the team's UART transmitter: it consumes the serial line a transmitter drives (loopback or external link) and presents received bytes on a valid/ready byte interface.
- Uses oversampled mid-bit sampling with start-bit glitch rejection.
- Reports framing errors and overruns.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and >= 4.
- TICK_DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE), derived; clocks per sample tick, integer truncation; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  8  last accepted received byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ready  input  1  consumer accepts the byte when data_valid && data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while data_valid still high.
- busy  output  1  high whenever FSM is not IDLE.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, async):
  - State is IDLE; tick divider and bit counters are 0.
  - Two-flop rx synchroniser presets to 1.
  - data_out=8'h00; data_valid, frame_err, overrun and busy are 0.
- Synchroniser: rx passes through 2 flops; rx_s is the second stage. All decisions use rx_s only.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; tick asserts for one clk when it wraps.
  - Counter is cleared on entry to START so the first tick lands exactly TICK_DIV clocks after the falling edge is detected.
- FSM states IDLE, START, DATA, STOP; sample counter s counts ticks, bit counter b is 0..7.
  - IDLE: on rx_s==0, go to START with s=0.
  - START: count ticks. When s reaches OVERSAMPLE/2-1, sample rx_s.
    - If rx_s==0: valid start; go to DATA with s=0, b=0.
    - If rx_s==1: glitch; return to IDLE, no outputs change.
  - DATA: on each tick where s==OVERSAMPLE-1, shift rx_s into the shift register at position b (LSB first) and reset s=0. After b==7 is sampled, go to STOP.
  - STOP: on the tick where s==OVERSAMPLE-1, sample rx_s.
    - If rx_s==1: complete the byte (see output rules) and return to IDLE.
    - If rx_s==0: pulse frame_err for one cycle and discard the byte. Wait in STOP until rx_s==1, then return to IDLE. A break condition never re-triggers a start.
- Latency: data_valid rises on the clk after the stop-bit sample tick.
- Output handshake:
  - On a good byte with data_valid==0: load data_out and set data_valid=1.
  - On a good byte with data_valid==1 and no transfer in that same cycle: pulse overrun, drop the new byte, keep the old data_out.
  - If a transfer and a completion occur in the same cycle: the transfer completes, the new byte loads, data_valid stays 1, no overrun.
  - data_valid clears on the clk after data_valid && data_ready.
  - data_out is stable while data_valid==1.
  - data_ready while data_valid==0 has no effect.
- Back-to-back frames: a new start bit is accepted from IDLE immediately after the stop sample, with no idle gap required.
- Reset mid-frame aborts the partial byte with no pulses. The FSM then resynchronises on the next falling edge.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving TICK_DIV=10 and 160 clk/bit.
1. Single frame 0xA5 with data_ready held low:
   - data_out=8'hA5 and data_valid=1 about 1.5 bit periods after the start edge plus 8 bits.
   - busy is high during the frame; frame_err=0 and overrun=0.
   - Then assert data_ready for 1 cycle: data_valid=0 on the next clk.
2. 60-clk low glitch on rx while idle: returns to IDLE, data_valid stays 0, busy drops within about 90 clks.
3. Frame 0x3C with the stop bit driven low, then rx held high:
   - frame_err pulses exactly 1 cycle, data_valid stays 0.
   - A following frame 0x42 is received correctly.
4. Frames 0x11 then 0x22 back-to-back with data_ready low:
   - data_out=8'h11 is retained.
   - overrun pulses once at the completion of the 0x22 frame.
5. Frames 0x55, 0xAA back-to-back with data_ready tied high: two data_valid pulses carrying 0x55 then 0xAA, no errors.
6. rst_n asserted low mid-DATA of frame 0xFF:
   - All outputs are 0 immediately (async).
   - After release, frame 0x81 is received correctly.
